// File: rtl/alu_result_q_pkg.sv
// ALU result queue shared definitions: widths, opcodes, FSM states.
// Optional feature macro: ALU_RESQ_PARITY_EN (per-entry even parity).
package alu_result_q_pkg;

  localparam int OP_W   = 3;
  localparam int ZCNT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SLL = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_FULL
  } q_state_e;

  function automatic logic [ZCNT_W-1:0] sat_inc(
    input logic [ZCNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/alu_result_q_if.sv
// ALU result queue handshake bundle (producer side + consumer side).
// Parity signals exist only with ALU_RESQ_PARITY_EN defined.
interface alu_result_q_if
  import alu_result_q_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic [OP_W-1:0]   out_op;
`ifdef ALU_RESQ_PARITY_EN
  logic              in_par;
  logic              out_par_err;
`endif

  modport slave (
    input  in_valid, in_result, in_zero, in_op, out_ready,
`ifdef ALU_RESQ_PARITY_EN
    input  in_par,
    output out_par_err,
`endif
    output in_ready, out_valid, out_result, out_zero, out_op
  );

  modport master (
    output in_valid, in_result, in_zero, in_op, out_ready,
`ifdef ALU_RESQ_PARITY_EN
    output in_par,
    input  out_par_err,
`endif
    input  in_ready, out_valid, out_result, out_zero, out_op
  );

endinterface

// File: rtl/alu_result_q_mem.sv
// ALU result queue storage: register array, one write port,
// one asynchronous read port. Contents are not reset.
module alu_result_q_mem #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // write the entry at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_q.sv
// ALU result queue: FIFO of {result, zero, op} with zero-flag stats.
// Define ALU_RESQ_PARITY_EN to carry and check per-entry parity.
module alu_result_q
  import alu_result_q_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_q_if.slave          bus,
  input  logic                   clr_stats,
  output logic [$clog2(DEPTH):0] count,
  output logic [ZCNT_W-1:0]      zero_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef ALU_RESQ_PARITY_EN
  localparam int EW = DATA_W + OP_W + 2;
`else
  localparam int EW = DATA_W + OP_W + 1;
`endif

  q_state_e      state;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          rdy;
  logic          vld;
  logic          push;
  logic          pop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign push          = bus.in_valid & rdy;
  assign pop           = vld & bus.out_ready;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;

`ifdef ALU_RESQ_PARITY_EN
  logic par_q;
  assign wdata = {bus.in_result, bus.in_zero, bus.in_op, bus.in_par};
  assign {bus.out_result, bus.out_zero, bus.out_op, par_q} = rdata;
  assign bus.out_par_err = vld & ((^bus.out_result) ^ par_q);
`else
  assign wdata = {bus.in_result, bus.in_zero, bus.in_op};
  assign {bus.out_result, bus.out_zero, bus.out_op} = rdata;
`endif

  alu_result_q_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  // occupancy FSM, pointers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdy   <= 1'b1;
      vld   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            state <= ST_ACTIVE;
            count <= CW'(1);
            vld   <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (push && !pop) begin
            count <= count + 1'b1;
            if (count == CW'(DEPTH - 1)) begin
              state <= ST_FULL;
              rdy   <= 1'b0;
            end
          end else if (pop && !push) begin
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state <= ST_EMPTY;
              vld   <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (pop) begin
            state <= ST_ACTIVE;
            count <= count - 1'b1;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= ST_EMPTY;
          count <= '0;
          rdy   <= 1'b1;
          vld   <= 1'b0;
        end
      endcase
    end
  end

  // saturating count of accepted zero results; clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
    end else if (clr_stats) begin
      zero_cnt <= '0;
    end else if (push && bus.in_zero) begin
      zero_cnt <= sat_inc(zero_cnt);
    end
  end

endmodule

// File: tb/tb_alu_result_q.sv
// Scoreboard bench for alu_result_q (DATA_W=8, DEPTH=4).
// Parity checks compile in with ALU_RESQ_PARITY_EN.
module tb_alu_result_q;
  import alu_result_q_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_stats = 1'b0;
  logic [2:0] count;
  logic [7:0] zero_cnt;

  alu_result_q_if #(.DATA_W(8)) bus ();

  alu_result_q #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clr_stats (clr_stats),
    .count     (count),
    .zero_cnt  (zero_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic [2:0] o;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] r,
                     input logic z, input logic [2:0] o);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_zero   = z;
    bus.in_op     = o;
`ifdef ALU_RESQ_PARITY_EN
    bus.in_par    = ^r;
`endif
  endtask

  // monitor: pop-compare on output handshake, record accepted pushes
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected none",
                   bus.out_result);
        end else begin
          e = sb.pop_front();
          chk("pop_result", 32'(bus.out_result), 32'(e.r));
          chk("pop_zero", 32'(bus.out_zero), 32'(e.z));
          chk("pop_op", 32'(bus.out_op), 32'(e.o));
`ifdef ALU_RESQ_PARITY_EN
          chk("pop_par_err", 32'(bus.out_par_err), 32'(e.pe));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.r  = bus.in_result;
        e.z  = bus.in_zero;
        e.o  = bus.in_op;
`ifdef ALU_RESQ_PARITY_EN
        e.pe = (^bus.in_result) ^ bus.in_par;
`else
        e.pe = 1'b0;
`endif
        sb.push_back(e);
      end
    end
  end

  initial begin
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
    rst_n = 1'b1;
    cyc();

    // single push visible one edge later
    drv(1'b1, 8'h12, 1'b0, 3'd0);
    cyc();
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_result", 32'(bus.out_result), 32'h12);
    chk("t1_count", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("t1_drained", 32'(count), 32'd0);

    // fill to full, fifth push held off, drain in order
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 8'(i), 1'b0, 3'd1);
      cyc();
    end
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    drv(1'b1, 8'h05, 1'b0, 3'd1);
    repeat (2) cyc();
    chk("t2_count_held", 32'(count), 32'd4);
    chk("t2_head_stable", 32'(bus.out_result), 32'h01);
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    bus.out_ready = 1'b0;
    chk("t2_count_empty", 32'(count), 32'd0);
    chk("t2_out_valid_empty", 32'(bus.out_valid), 32'd0);
    chk("t2_in_ready_empty", 32'(bus.in_ready), 32'd1);

    // steady push+pop at count 2 across pointer wrap
    drv(1'b1, 8'hA0, 1'b0, 3'd2);
    cyc();
    drv(1'b1, 8'hA1, 1'b1, 3'd3);
    cyc();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 8'h20 + 8'(i), 1'(i % 2), 3'(i % 7));
      cyc();
      chk("t3_count_hold", 32'(count), 32'd2);
    end
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    repeat (2) cyc();
    bus.out_ready = 1'b0;
    chk("t3_drained", 32'(count), 32'd0);

    // zero counter saturation and clear priority
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drv(1'b1, 8'h00, 1'b1, 3'd1);
      cyc();
    end
    chk("t4_zero_sat", 32'(zero_cnt), 32'd255);
    clr_stats = 1'b1;
    drv(1'b1, 8'h00, 1'b1, 3'd0);
    cyc();
    clr_stats = 1'b0;
    chk("t4_clr_wins", 32'(zero_cnt), 32'd0);
    drv(1'b1, 8'h00, 1'b1, 3'd0);
    cyc();
    chk("t4_count_again", 32'(zero_cnt), 32'd1);
    drv(1'b1, 8'h09, 1'b0, 3'd4);
    cyc();
    chk("t4_nonzero_skip", 32'(zero_cnt), 32'd1);
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    cyc();
    bus.out_ready = 1'b0;
    chk("t4_drained", 32'(count), 32'd0);

    // asynchronous reset mid-cycle with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 8'h50 + 8'(i), 1'b0, 3'd2);
      cyc();
    end
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    chk("t5_count_pre", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_async_zcnt", 32'(zero_cnt), 32'd0);
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
    drv(1'b1, 8'h77, 1'b1, 3'd5);
    cyc();
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    chk("t5_head_result", 32'(bus.out_result), 32'h77);
    chk("t5_head_op", 32'(bus.out_op), 32'd5);
    chk("t5_count_one", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("t5_drained", 32'(count), 32'd0);

`ifdef ALU_RESQ_PARITY_EN
    // stored parity bit against recomputed parity of the result
    drv(1'b1, 8'h03, 1'b0, 3'd0);
    bus.in_par = 1'b1;
    cyc();
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    chk("t6_par_err_set", 32'(bus.out_par_err), 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk("t6_par_err_idle", 32'(bus.out_par_err), 32'd0);
    drv(1'b1, 8'h03, 1'b0, 3'd0);
    bus.in_par = 1'b0;
    cyc();
    drv(1'b0, 8'h00, 1'b0, 3'd0);
    chk("t6_par_err_clr", 32'(bus.out_par_err), 32'd0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
`endif

    cyc();
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
